// File: rtl/sprite_pkg.sv
// Shared sprite types and constants: animation modes, per-mode base states, state width.
// Imported by the animation sequencer and, later, the sheet position mux.
package sprite_pkg;

  localparam int SPRITE_STATE_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WALK   = 2'd1,
    RUN    = 2'd2,
    ATTACK = 2'd3
  } anim_mode_t;

  localparam logic [SPRITE_STATE_W-1:0] BASE_IDLE   = 4'd0;
  localparam logic [SPRITE_STATE_W-1:0] BASE_WALK   = 4'd4;
  localparam logic [SPRITE_STATE_W-1:0] BASE_RUN    = 4'd8;
  localparam logic [SPRITE_STATE_W-1:0] BASE_ATTACK = 4'd12;

  function automatic logic [SPRITE_STATE_W-1:0] mode_base(input anim_mode_t m);
    logic [SPRITE_STATE_W-1:0] b;
    case (m)
      IDLE:    b = BASE_IDLE;
      WALK:    b = BASE_WALK;
      RUN:     b = BASE_RUN;
      default: b = BASE_ATTACK;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/sprite_anim_seq_frame_pacer.sv
// Frame pacer: counts frame ticks, raises a combinational step on the last tick of each step.
// Step is same-cycle as the closing tick; clear wins over tick and suppresses step.
module frame_pacer #(
  parameter int unsigned FRAMES_PER_STEP = 6
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic clear,
  output logic step
);

  localparam int CW = $clog2(FRAMES_PER_STEP + 1);
  localparam logic [CW-1:0] LAST = CW'(FRAMES_PER_STEP - 1);

  logic [CW-1:0] cnt;
  logic          at_last;

  assign at_last = (cnt == LAST);
  assign step    = tick && !clear && at_last;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= at_last ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/sprite_anim_seq.sv
// Sprite animation sequencer: IR mode commands + frame pacing -> 4-bit sprite state, 1-cycle registered.
// Optional SPRITE_HOLD_EN adds a CMD_HOLD toggle that freezes pacing.
module sprite_anim_seq
  import sprite_pkg::*;
#(
  parameter int unsigned FRAMES_PER_STEP = 6,
  parameter logic [7:0]  CMD_IDLE        = 8'h16,
  parameter logic [7:0]  CMD_WALK        = 8'h19,
  parameter logic [7:0]  CMD_RUN         = 8'h0D,
  parameter logic [7:0]  CMD_ATTACK      = 8'h1C
`ifdef SPRITE_HOLD_EN
  ,
  parameter logic [7:0]  CMD_HOLD        = 8'h40
`endif
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      frame_tick,
  input  logic                      ir_valid,
  input  logic [7:0]                ir_cmd,
  output logic [SPRITE_STATE_W-1:0] sprite_state,
  output logic [1:0]                anim_mode,
  output logic                      anim_busy,
  output logic                      step_strobe
);

  anim_mode_t                mode_q;
  anim_mode_t                ret_q;
  logic [SPRITE_STATE_W-1:0] state_q;
  logic                      busy_q;
  logic                      strobe_q;

  anim_mode_t cmd_mode;
  logic       cmd_is_mode;
  logic       accept_mode;
  logic       accept_att;
  logic       accept_hold;
  logic       hold_act;
  logic       pace_tick;
  logic       pace_clear;
  logic       step;

  always_comb begin
    cmd_mode    = IDLE;
    cmd_is_mode = 1'b0;
    if (ir_cmd == CMD_IDLE) begin
      cmd_mode    = IDLE;
      cmd_is_mode = 1'b1;
    end else if (ir_cmd == CMD_WALK) begin
      cmd_mode    = WALK;
      cmd_is_mode = 1'b1;
    end else if (ir_cmd == CMD_RUN) begin
      cmd_mode    = RUN;
      cmd_is_mode = 1'b1;
    end
  end

  // While busy mode_q is ATTACK, so every mode command "differs"; busy gates it.
  assign accept_mode = ir_valid && cmd_is_mode && !busy_q && (cmd_mode != mode_q);
  assign accept_att  = ir_valid && (ir_cmd == CMD_ATTACK) && !busy_q;

`ifdef SPRITE_HOLD_EN
  logic hold_q;

  assign accept_hold = ir_valid && (ir_cmd == CMD_HOLD);
  assign hold_act    = hold_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hold_q <= 1'b0;
    end else if (accept_hold) begin
      hold_q <= !hold_q;
    end
  end
`else
  assign accept_hold = 1'b0;
  assign hold_act    = 1'b0;
`endif

  // Any accepted command swallows a coincident tick.
  assign pace_clear = accept_mode || accept_att;
  assign pace_tick  = frame_tick && !hold_act && !(pace_clear || accept_hold);

  frame_pacer #(
    .FRAMES_PER_STEP(FRAMES_PER_STEP)
  ) u_pacer (
    .clk    (clk),
    .reset_n(reset_n),
    .tick   (pace_tick),
    .clear  (pace_clear),
    .step   (step)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mode_q   <= IDLE;
      ret_q    <= IDLE;
      state_q  <= BASE_IDLE;
      busy_q   <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      if (accept_mode) begin
        mode_q  <= cmd_mode;
        state_q <= mode_base(cmd_mode);
      end else if (accept_att) begin
        ret_q   <= mode_q;
        mode_q  <= ATTACK;
        state_q <= BASE_ATTACK;
        busy_q  <= 1'b1;
      end else if (step) begin
        strobe_q <= 1'b1;
        if (busy_q && (state_q[1:0] == 2'b11)) begin
          mode_q  <= ret_q;
          state_q <= mode_base(ret_q);
          busy_q  <= 1'b0;
        end else begin
          state_q <= {state_q[3:2], state_q[1:0] + 2'd1};
        end
      end
    end
  end

  assign sprite_state = state_q;
  assign anim_mode    = mode_q;
  assign anim_busy    = busy_q;
  assign step_strobe  = strobe_q;

endmodule

// File: tb/tb_sprite_anim_seq.sv
// Bench for sprite_anim_seq: directed walk-through plus random IR/tick traffic against a behavioural model.
module tb_sprite_anim_seq;

  localparam int FPS = 4;
  localparam logic [7:0] C_IDLE = 8'h16;
  localparam logic [7:0] C_WALK = 8'h19;
  localparam logic [7:0] C_RUN  = 8'h0D;
  localparam logic [7:0] C_ATT  = 8'h1C;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       ir_valid = 1'b0;
  logic [7:0] ir_cmd = 8'h00;
  logic [3:0] sprite_state;
  logic [1:0] anim_mode;
  logic       anim_busy;
  logic       step_strobe;

  int n_tests = 0;
  int n_fail  = 0;
  int strobe_cnt = 0;

  // Reference state: plain integers following the written rules.
  int m_mode = 0, m_state = 0, m_busy = 0, m_strobe = 0, m_ret = 0, m_ticks = 0;

  sprite_anim_seq #(
    .FRAMES_PER_STEP(FPS),
    .CMD_IDLE(C_IDLE),
    .CMD_WALK(C_WALK),
    .CMD_RUN(C_RUN),
    .CMD_ATTACK(C_ATT)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .frame_tick(frame_tick),
    .ir_valid(ir_valid),
    .ir_cmd(ir_cmd),
    .sprite_state(sprite_state),
    .anim_mode(anim_mode),
    .anim_busy(anim_busy),
    .step_strobe(step_strobe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic v, input logic [7:0] c, input logic t, input logic rn);
    int cm;
    bit taken;
    if (!rn) begin
      m_mode = 0; m_state = 0; m_busy = 0; m_strobe = 0; m_ret = 0; m_ticks = 0;
      return;
    end
    m_strobe = 0;
    taken = 0;
    if (v) begin
      cm = -1;
      if (c == C_IDLE) cm = 0;
      else if (c == C_WALK) cm = 1;
      else if (c == C_RUN) cm = 2;
      if (m_busy == 0 && cm >= 0 && cm != m_mode) begin
        m_mode = cm; m_state = 4 * cm; m_ticks = 0; taken = 1;
      end else if (m_busy == 0 && c == C_ATT) begin
        m_ret = m_mode; m_mode = 3; m_state = 12; m_busy = 1; m_ticks = 0; taken = 1;
      end
    end
    if (t && !taken) begin
      m_ticks++;
      if (m_ticks == FPS) begin
        m_ticks = 0;
        m_strobe = 1;
        if (m_busy == 1 && m_state == 15) begin
          m_mode = m_ret; m_state = 4 * m_ret; m_busy = 0;
        end else begin
          m_state = 4 * m_mode + ((m_state - 4 * m_mode + 1) % 4);
        end
      end
    end
  endtask

  task automatic cycle(input logic v, input logic [7:0] c, input logic t, input logic rn);
    ir_valid = v; ir_cmd = c; frame_tick = t; reset_n = rn;
    @(posedge clk);
    model_step(v, c, t, rn);
    #1;
    if (step_strobe) strobe_cnt++;
    chk("state", int'(sprite_state), m_state);
    chk("mode", int'(anim_mode), m_mode);
    chk("busy", int'(anim_busy), m_busy);
    chk("strobe", int'(step_strobe), m_strobe);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b1, 1'b1);
  endtask

  initial begin
    logic [7:0] cmds[7];
    logic [7:0] c;
    cmds[0] = C_IDLE; cmds[1] = C_WALK; cmds[2] = C_RUN; cmds[3] = C_ATT;
    cmds[4] = 8'hFF;  cmds[5] = 8'h40;  cmds[6] = 8'h00;

    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("rst_state", int'(sprite_state), 0);
    chk("rst_mode", int'(anim_mode), 0);
    chk("rst_busy", int'(anim_busy), 0);
    chk("rst_strobe", int'(step_strobe), 0);

    strobe_cnt = 0;
    ticks(3);
    chk("t3_state", int'(sprite_state), 0);
    ticks(1);
    chk("t4_state", int'(sprite_state), 1);
    ticks(8);
    chk("t12_state", int'(sprite_state), 3);
    chk("t12_strobes", strobe_cnt, 3);

    ticks(12);
    chk("idle_at2", int'(sprite_state), 2);
    cycle(1'b1, C_WALK, 1'b0, 1'b1);
    chk("walk_state", int'(sprite_state), 4);
    chk("walk_mode", int'(anim_mode), 1);
    ticks(3);
    chk("walk_t3", int'(sprite_state), 4);
    ticks(1);
    chk("walk_t4", int'(sprite_state), 5);
    ticks(12);
    chk("walk_wrap", int'(sprite_state), 4);
    cycle(1'b1, C_WALK, 1'b0, 1'b1);
    ticks(4);
    chk("walk_same_cmd", int'(sprite_state), 5);

    cycle(1'b1, C_RUN, 1'b0, 1'b1);
    chk("run_state", int'(sprite_state), 8);
    cycle(1'b1, C_ATT, 1'b0, 1'b1);
    chk("att_state", int'(sprite_state), 12);
    chk("att_busy", int'(anim_busy), 1);
    ticks(4);
    chk("att_13", int'(sprite_state), 13);
    cycle(1'b1, C_IDLE, 1'b0, 1'b1);
    cycle(1'b1, C_ATT, 1'b1, 1'b1);
    chk("att_ignored", int'(sprite_state), 13);
    ticks(3);
    chk("att_14", int'(sprite_state), 14);
    ticks(4);
    chk("att_15", int'(sprite_state), 15);
    ticks(4);
    chk("att_ret_state", int'(sprite_state), 8);
    chk("att_ret_busy", int'(anim_busy), 0);
    chk("att_ret_mode", int'(anim_mode), 2);

    cycle(1'b1, C_WALK, 1'b0, 1'b1);
    ticks(3);
    cycle(1'b1, C_RUN, 1'b1, 1'b1);
    chk("coin_run_state", int'(sprite_state), 8);
    chk("coin_run_strobe", int'(step_strobe), 0);
    cycle(1'b1, C_WALK, 1'b0, 1'b1);
    ticks(3);
    cycle(1'b1, 8'hFF, 1'b1, 1'b1);
    chk("coin_ff_state", int'(sprite_state), 5);
    chk("coin_ff_strobe", int'(step_strobe), 1);

    cycle(1'b1, C_ATT, 1'b0, 1'b1);
    ticks(8);
    chk("pre_rst_14", int'(sprite_state), 14);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("midatt_rst_state", int'(sprite_state), 0);
    chk("midatt_rst_busy", int'(anim_busy), 0);
    chk("midatt_rst_mode", int'(anim_mode), 0);
    cycle(1'b1, C_ATT, 1'b0, 1'b1);
    ticks(16);
    chk("reatt_state", int'(sprite_state), 0);
    chk("reatt_mode", int'(anim_mode), 0);

    for (int i = 0; i < 4000; i++) begin
      c = cmds[$urandom_range(0, 6)];
      if (c == 8'h00) c = 8'($urandom);
      cycle(($urandom_range(0, 3) == 0), c, ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 299) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
